// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// stall hold vectors and the zero word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EX_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Hold vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_LOADUSE = 6'b000111;
  localparam logic [5:0] STALL_EXBUSY  = 6'b001111;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/busy_watchdog.sv
// Cycle counter for time spent waiting on an EX multi-cycle op; flags the
// last allowed busy cycle (count == LIMIT-1).
module busy_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic limit_hit
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // The controller leaves EX_BUSY on this flag, so the counter never wraps.
  assign limit_hit = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use and EX multi-cycle interlocks,
// redirect flush with priority, EX watchdog and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             ex_done,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  input  logic             cnt_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_abort,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output state_t           state
);

  state_t next_state;
  logic   abort_set;
  logic   timeout_set;
  logic   wd_hit;

  busy_watchdog #(
    .LIMIT(BUSY_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != EX_BUSY),
    .enable   (state == EX_BUSY),
    .limit_hit(wd_hit)
  );

  always_comb begin
    next_state  = state;
    stall       = STALL_NONE;
    abort_set   = 1'b0;
    timeout_set = 1'b0;
    if (flush_req) begin
      // Redirect beats every stall request and a coincident ex_done.
      next_state = FLUSH;
      abort_set  = (state == EX_BUSY);
    end else begin
      case (state)
        IDLE: begin
          if (stallreq_ex) begin
            stall      = STALL_EXBUSY;
            next_state = EX_BUSY;
          end else if (stallreq_id) begin
            stall = STALL_LOADUSE;
          end
        end
        EX_BUSY: begin
          if (ex_done) begin
            next_state = IDLE;
          end else begin
            stall = STALL_EXBUSY;
            if (wd_hit) begin
              next_state  = IDLE;
              abort_set   = 1'b1;
              timeout_set = 1'b1;
            end
          end
        end
        FLUSH:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
    // The hold vector must read zero while reset is asserted.
    if (!rst) begin
      stall = STALL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      flush       <= 1'b0;
      new_pc      <= ZeroWord;
      ex_abort    <= 1'b0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state    <= next_state;
      flush    <= flush_req;
      ex_abort <= abort_set;
      if (flush_req) begin
        new_pc <= flush_pc;
      end
      if (timeout_set) begin
        timeout_err <= 1'b1;
      end
      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if ((stall != STALL_NONE) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a small instance
// (BUSY_TIMEOUT=4, CNT_W=4) share stimulus; each scenario checks one of them.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        ex_done = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        cnt_clr = 1'b0;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [31:0] new_pc_a, new_pc_b;
  logic        ex_abort_a, ex_abort_b;
  logic        timeout_err_a, timeout_err_b;
  logic [31:0] stall_cnt_a;
  logic [3:0]  stall_cnt_b;
  state_t      state_a, state_b;

  int err_cnt = 0;
  int chk_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  pipe_ctrl dut_a (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_done(ex_done), .flush_req(flush_req), .flush_pc(flush_pc), .cnt_clr(cnt_clr),
    .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a), .ex_abort(ex_abort_a),
    .timeout_err(timeout_err_a), .stall_cnt(stall_cnt_a), .state(state_a)
  );

  pipe_ctrl #(.BUSY_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_done(ex_done), .flush_req(flush_req), .flush_pc(flush_pc), .cnt_clr(cnt_clr),
    .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b), .ex_abort(ex_abort_b),
    .timeout_err(timeout_err_b), .stall_cnt(stall_cnt_b), .state(state_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    ex_done     = 1'b0;
    flush_req   = 1'b0;
    flush_pc    = 32'h0;
    cnt_clr     = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("rst_stall", 32'(stall_a), 32'h0);
    chk("rst_flush", 32'(flush_a), 32'h0);
    chk("rst_new_pc", new_pc_a, 32'h0);
    chk("rst_ex_abort", 32'(ex_abort_a), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err_a), 32'h0);
    chk("rst_stall_cnt", stall_cnt_a, 32'h0);
    chk("rst_state", 32'(state_a), 32'(IDLE));
    next_cyc();
    rst = 1'b1;
  endtask

  initial begin
    // load-use stall for two cycles
    apply_reset();
    stallreq_id = 1'b1;
    @(negedge clk); chk("lu_stall_c0", 32'(stall_a), 32'h07);
    next_cyc();
    @(negedge clk); chk("lu_stall_c1", 32'(stall_a), 32'h07);
    chk("lu_state_c1", 32'(state_a), 32'(IDLE));
    next_cyc();
    stallreq_id = 1'b0;
    @(negedge clk); chk("lu_stall_c2", 32'(stall_a), 32'h00);
    chk("lu_cnt", stall_cnt_a, 32'd2);

    // EX multi-cycle op completing at cycle 5
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      stallreq_ex = 1'b1;
      @(negedge clk); chk($sformatf("ex_stall_c%0d", k), 32'(stall_a), 32'h0F);
      next_cyc();
    end
    stallreq_ex = 1'b0;
    ex_done     = 1'b1;
    @(negedge clk); chk("ex_stall_c5", 32'(stall_a), 32'h00);
    chk("ex_state_c5", 32'(state_a), 32'(EX_BUSY));
    next_cyc();
    ex_done = 1'b0;
    @(negedge clk); chk("ex_state_c6", 32'(state_a), 32'(IDLE));
    chk("ex_stall_c6", 32'(stall_a), 32'h00);
    chk("ex_cnt_c6", stall_cnt_a, 32'd5);
    chk("ex_no_abort", 32'(ex_abort_a), 32'h0);

    // watchdog timeout on the BUSY_TIMEOUT=4 instance
    apply_reset();
    stallreq_ex = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("wd_stall_c%0d", k), 32'(stall_b), 32'h0F);
      chk($sformatf("wd_abort_c%0d", k), 32'(ex_abort_b), 32'h0);
      next_cyc();
    end
    stallreq_ex = 1'b0;
    @(negedge clk);
    chk("wd_abort_c5", 32'(ex_abort_b), 32'h1);
    chk("wd_timeout_c5", 32'(timeout_err_b), 32'h1);
    chk("wd_state_c5", 32'(state_b), 32'(IDLE));
    next_cyc();
    @(negedge clk);
    chk("wd_abort_c6", 32'(ex_abort_b), 32'h0);
    chk("wd_timeout_sticky", 32'(timeout_err_b), 32'h1);

    // flush during EX_BUSY coinciding with ex_done, then back-to-back flushes
    apply_reset();
    stallreq_ex = 1'b1;
    next_cyc();
    next_cyc();
    stallreq_ex = 1'b0;
    ex_done     = 1'b1;
    flush_req   = 1'b1;
    flush_pc    = 32'hBFC0_0380;
    @(negedge clk); chk("fl_stall_req", 32'(stall_a), 32'h00);
    next_cyc();
    clear_inputs();
    @(negedge clk);
    chk("fl_flush", 32'(flush_a), 32'h1);
    chk("fl_new_pc", new_pc_a, 32'hBFC0_0380);
    chk("fl_abort", 32'(ex_abort_a), 32'h1);
    chk("fl_state", 32'(state_a), 32'(FLUSH));
    chk("fl_timeout", 32'(timeout_err_a), 32'h0);
    next_cyc();
    flush_req   = 1'b1;
    flush_pc    = 32'h0000_1000;
    stallreq_id = 1'b1;
    @(negedge clk);
    chk("fl_idle", 32'(state_a), 32'(IDLE));
    chk("fl_flush_off", 32'(flush_a), 32'h0);
    chk("fl_pc_hold", new_pc_a, 32'hBFC0_0380);
    chk("fl_prio_stall", 32'(stall_a), 32'h00);
    next_cyc();
    flush_pc = 32'h0000_2000;
    @(negedge clk);
    chk("fl2_state", 32'(state_a), 32'(FLUSH));
    chk("fl2_pc", new_pc_a, 32'h0000_1000);
    chk("fl2_stall", 32'(stall_a), 32'h00);
    next_cyc();
    flush_req = 1'b0;
    @(negedge clk);
    chk("fl3_state", 32'(state_a), 32'(FLUSH));
    chk("fl3_pc", new_pc_a, 32'h0000_2000);
    chk("fl3_abort", 32'(ex_abort_a), 32'h0);
    chk("fl3_stall_ignored", 32'(stall_a), 32'h00);
    next_cyc();
    @(negedge clk);
    chk("fl4_state", 32'(state_a), 32'(IDLE));
    chk("fl4_flush", 32'(flush_a), 32'h0);
    chk("fl4_stall_reeval", 32'(stall_a), 32'h07);
    chk("fl4_pc_hold", new_pc_a, 32'h0000_2000);
    next_cyc();
    clear_inputs();

    // asynchronous reset between edges in EX_BUSY
    apply_reset();
    stallreq_ex = 1'b1;
    next_cyc();
    next_cyc();
    #2 rst = 1'b0;
    #1;
    chk("ar_stall", 32'(stall_a), 32'h00);
    chk("ar_state", 32'(state_a), 32'(IDLE));
    chk("ar_cnt", stall_cnt_a, 32'h0);
    chk("ar_flush", 32'(flush_a), 32'h0);
    chk("ar_abort", 32'(ex_abort_a), 32'h0);
    chk("ar_stall_b", 32'(stall_b), 32'h00);
    stallreq_ex = 1'b0;
    next_cyc();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ar_rel_abort_c%0d", k), 32'(ex_abort_a), 32'h0);
      chk($sformatf("ar_rel_flush_c%0d", k), 32'(flush_a), 32'h0);
      chk($sformatf("ar_rel_state_c%0d", k), 32'(state_a), 32'(IDLE));
      next_cyc();
    end

    // saturation and clear of the 4-bit counter
    apply_reset();
    for (int k = 0; k < 18; k++) begin
      stallreq_id = 1'b1;
      @(negedge clk);
      if (k == 14) chk("sat_cnt_e", 32'(stall_cnt_b), 32'hE);
      if (k >= 16) chk($sformatf("sat_cnt_c%0d", k), 32'(stall_cnt_b), 32'hF);
      next_cyc();
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_before", 32'(stall_cnt_b), 32'hF);
    chk("clr_stall", 32'(stall_b), 32'h07);
    next_cyc();
    cnt_clr = 1'b0;
    @(negedge clk); chk("clr_zero", 32'(stall_cnt_b), 32'h0);
    next_cyc();
    @(negedge clk); chk("clr_restart", 32'(stall_cnt_b), 32'h1);
    next_cyc();
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
